// File: rtl/regfile_writeback_scheduler.sv
// Round-robin arbiter sharing the register bank's single write port between
// NUM_REQ writeback sources, with a registered write port and a pending-write scoreboard.
module regfile_writeback_scheduler #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  reqRegister,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  reqData,
  output logic [NUM_REQ-1:0]             gnt,
  input  logic                           hold,
  input  logic                           issueValid,
  input  logic [ADDR_WIDTH-1:0]          issueRegister,
  input  logic [ADDR_WIDTH-1:0]          readRegister1,
  input  logic [ADDR_WIDTH-1:0]          readRegister2,
  output logic                           hazard1,
  output logic                           hazard2,
  output logic                           RegWrite,
  output logic [ADDR_WIDTH-1:0]          writeRegister,
  output logic [DATA_WIDTH-1:0]          writeData,
  output logic [31:0]                    pendingMask
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]      last_q, last_d;
  logic [IDX_W-1:0]      cand_s, sel_idx_s;
  logic                  found_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic                  xfer_s, wr_en_s;
  logic [31:0]           set_vec_s, clr_vec_s;
  logic                  regwrite_q, regwrite_d;
  logic [ADDR_WIDTH-1:0] wreg_q, wreg_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [31:0]           pend_q, pend_d;

  // Search starts one past the last winner and wraps; reset or hold suppress all grants.
  always_comb begin
    found_s   = 1'b0;
    sel_idx_s = '0;
    cand_s    = '0;
    gnt       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s = IDX_W'((int'(last_q) + k) % NUM_REQ);
      if (!found_s && req[cand_s]) begin
        found_s   = 1'b1;
        sel_idx_s = cand_s;
      end else begin
        found_s   = found_s;
      end
    end
    if (reset || hold || !found_s) begin
      gnt = '0;
    end else begin
      gnt[sel_idx_s] = 1'b1;
    end
  end

  always_comb begin
    sel_addr_s = '0;
    sel_data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr_s = reqRegister[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data_s = reqData[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        sel_addr_s = sel_addr_s;
      end
    end
  end

  // Transfers to r0 complete the handshake but never reach the bank or the scoreboard.
  always_comb begin
    xfer_s     = |gnt;
    wr_en_s    = xfer_s && (sel_addr_s != '0);
    last_d     = xfer_s ? sel_idx_s : last_q;
    regwrite_d = wr_en_s;
    wreg_d     = wr_en_s ? sel_addr_s : wreg_q;
    wdata_d    = wr_en_s ? sel_data_s : wdata_q;
    if (issueValid && (issueRegister != '0)) begin
      set_vec_s = 32'd1 << issueRegister;
    end else begin
      set_vec_s = 32'd0;
    end
    if (wr_en_s) begin
      clr_vec_s = 32'd1 << sel_addr_s;
    end else begin
      clr_vec_s = 32'd0;
    end
    // A new producer issued on the clearing edge keeps the bit set.
    pend_d = (pend_q & ~clr_vec_s) | set_vec_s;
  end

  // State register for pointer, write port and scoreboard.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_q     <= IDX_W'(NUM_REQ - 1);
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
      pend_q     <= 32'd0;
    end else begin
      last_q     <= last_d;
      regwrite_q <= regwrite_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      pend_q     <= pend_d;
    end
  end

  assign RegWrite      = regwrite_q;
  assign writeRegister = wreg_q;
  assign writeData     = wdata_q;
  assign pendingMask   = pend_q;
  assign hazard1       = pend_q[readRegister1];
  assign hazard2       = pend_q[readRegister2];

endmodule

// File: tb/tb_regfile_writeback_scheduler.sv
// Randomized and directed bench for regfile_writeback_scheduler against a
// transaction-level reference model (pointer, scoreboard bitmap, expected write).
module tb_regfile_writeback_scheduler;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 5;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*AW-1:0] reqRegister;
  logic [N*DW-1:0] reqData;
  logic [N-1:0]    gnt;
  logic            hold, issueValid;
  logic [AW-1:0]   issueRegister, readRegister1, readRegister2;
  logic            hazard1, hazard2, RegWrite;
  logic [AW-1:0]   writeRegister;
  logic [DW-1:0]   writeData;
  logic [31:0]     pendingMask;

  regfile_writeback_scheduler #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .req(req), .reqRegister(reqRegister), .reqData(reqData),
    .gnt(gnt), .hold(hold), .issueValid(issueValid), .issueRegister(issueRegister),
    .readRegister1(readRegister1), .readRegister2(readRegister2), .hazard1(hazard1),
    .hazard2(hazard2), .RegWrite(RegWrite), .writeRegister(writeRegister),
    .writeData(writeData), .pendingMask(pendingMask)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus state: each requester keeps its write until granted.
  bit          rst_v, hold_v, iv_v;
  int          ireg_v, rr1_v, rr2_v;
  bit          req_v  [N];
  int          addr_v [N];
  logic [31:0] data_v [N];

  // Reference model.
  int          exp_last;
  bit [31:0]   exp_pend;
  bit          exp_rw;
  int          exp_wr;
  logic [31:0] exp_wd;

  // Values observed in the most recent cycle.
  logic [N-1:0] obs_gnt;
  logic         obs_haz1;
  logic [31:0]  obs_pend;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_stim();
    rst_v = 1'b0; hold_v = 1'b0; iv_v = 1'b0; ireg_v = 0; rr1_v = 0; rr2_v = 0;
    for (int i = 0; i < N; i++) begin
      req_v[i] = 1'b0; addr_v[i] = 0; data_v[i] = 32'd0;
    end
  endtask

  // One clock: drive, check against the model, advance the model across the edge.
  task automatic cycle();
    int gi;
    logic [N-1:0] eg;
    reset = rst_v; hold = hold_v; issueValid = iv_v;
    issueRegister = AW'(ireg_v); readRegister1 = AW'(rr1_v); readRegister2 = AW'(rr2_v);
    for (int i = 0; i < N; i++) begin
      req[i] = req_v[i];
      reqRegister[i*AW +: AW] = AW'(addr_v[i]);
      reqData[i*DW +: DW] = data_v[i];
    end
    #2;
    gi = -1;
    if (!rst_v && !hold_v) begin
      for (int k = 1; k <= N; k++) begin
        if (gi < 0 && req_v[(exp_last + k) % N]) gi = (exp_last + k) % N;
      end
    end
    eg = '0;
    if (gi >= 0) eg[gi] = 1'b1;
    check_value("gnt", 64'(gnt), 64'(eg));
    check_value("hazard1", 64'(hazard1), 64'(exp_pend[rr1_v]));
    check_value("hazard2", 64'(hazard2), 64'(exp_pend[rr2_v]));
    check_value("RegWrite", 64'(RegWrite), 64'(exp_rw));
    check_value("writeRegister", 64'(writeRegister), 64'(exp_wr));
    check_value("writeData", 64'(writeData), 64'(exp_wd));
    check_value("pendingMask", 64'(pendingMask), 64'(exp_pend));
    obs_gnt = gnt; obs_haz1 = hazard1; obs_pend = pendingMask;
    if (rst_v) begin
      exp_last = N - 1; exp_pend = '0; exp_rw = 1'b0; exp_wr = 0; exp_wd = 32'd0;
    end else begin
      exp_rw = 1'b0;
      if (gi >= 0) begin
        exp_last = gi;
        if (addr_v[gi] != 0) begin
          exp_rw = 1'b1; exp_wr = addr_v[gi]; exp_wd = data_v[gi];
          exp_pend[addr_v[gi]] = 1'b0;
        end
      end
      if (iv_v && ireg_v != 0) exp_pend[ireg_v] = 1'b1;
    end
    @(posedge clock);
    #1;
    if (gi >= 0) req_v[gi] = 1'b0;
  endtask

  task automatic do_reset();
    clear_stim();
    rst_v = 1'b1;
    cycle();
    rst_v = 1'b0;
  endtask

  initial begin
    exp_last = N - 1; exp_pend = '0; exp_rw = 1'b0; exp_wr = 0; exp_wd = 32'd0;
    @(posedge clock);
    #1;
    do_reset();

    // 1: all requesters continuously asserted rotate 0,1,2,0.
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < N; i++) begin
        req_v[i] = 1'b1; addr_v[i] = 5 + i; data_v[i] = 32'hA + 32'(i);
      end
      cycle();
      if (c < 4) check_value("p1_gnt", 64'(obs_gnt), 64'(3'b001 << (c % 3)));
    end

    // 2: req0/req2 alternate, req1 raised later is served within 3 cycles.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      req_v[0] = 1'b1; addr_v[0] = 1; data_v[0] = 32'h100 + 32'(c);
      req_v[2] = 1'b1; addr_v[2] = 3; data_v[2] = 32'h300 + 32'(c);
      if (c == 4) begin req_v[1] = 1'b1; addr_v[1] = 2; data_v[1] = 32'h222; end
      cycle();
      if (c < 4) check_value("p2_alt", 64'(obs_gnt), (c % 2 == 0) ? 64'h1 : 64'h4);
    end
    check_value("p2_req1_served", 64'(req_v[1]), 64'h0);

    // 3: write to r0 is granted but never reaches the bank.
    do_reset();
    req_v[0] = 1'b1; addr_v[0] = 0; data_v[0] = 32'hFFFF_FFFF;
    cycle();
    check_value("p3_gnt", 64'(obs_gnt), 64'h1);
    cycle();
    check_value("p3_regwrite", 64'(RegWrite), 64'h0);
    check_value("p3_pend", 64'(obs_pend), 64'h0);

    // 4: scoreboard set, clear, and set-wins-over-clear.
    do_reset();
    iv_v = 1'b1; ireg_v = 8; rr1_v = 8;
    cycle();
    iv_v = 1'b0;
    cycle();
    check_value("p4_haz_set", 64'(obs_haz1), 64'h1);
    req_v[1] = 1'b1; addr_v[1] = 8; data_v[1] = 32'h1234_5678;
    cycle();
    cycle();
    check_value("p4_haz_clr", 64'(obs_haz1), 64'h0);
    check_value("p4_pend_clr", 64'(obs_pend[8]), 64'h0);
    iv_v = 1'b1; ireg_v = 8;
    cycle();
    req_v[0] = 1'b1; addr_v[0] = 8; data_v[0] = 32'h8888;
    cycle();
    iv_v = 1'b0;
    cycle();
    check_value("p4_set_wins", 64'(obs_pend[8]), 64'h1);

    // 5: hold blocks grants; release grants last+1.
    do_reset();
    req_v[0] = 1'b1; addr_v[0] = 4; data_v[0] = 32'h44;
    cycle();
    for (int c = 0; c < 4; c++) begin
      hold_v = 1'b1;
      for (int i = 0; i < N; i++) begin
        req_v[i] = 1'b1; addr_v[i] = 10 + i; data_v[i] = 32'h50 + 32'(i);
      end
      cycle();
      check_value("p5_hold_gnt", 64'(obs_gnt), 64'h0);
    end
    hold_v = 1'b0;
    cycle();
    check_value("p5_release", 64'(obs_gnt), 64'h2);

    // 6: reset during a transfer discards it and restores the pointer.
    do_reset();
    req_v[1] = 1'b1; addr_v[1] = 11; data_v[1] = 32'h11;
    iv_v = 1'b1; ireg_v = 12;
    cycle();
    iv_v = 1'b0;
    rst_v = 1'b1;
    req_v[0] = 1'b1; addr_v[0] = 9; data_v[0] = 32'h99;
    req_v[2] = 1'b1; addr_v[2] = 13; data_v[2] = 32'h13;
    cycle();
    rst_v = 1'b0;
    cycle();
    check_value("p6_gnt_after", 64'(obs_gnt), 64'h1);
    check_value("p6_pend", 64'(obs_pend), 64'h0);

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst_v  = ($urandom_range(0, 59) == 0);
      hold_v = ($urandom_range(0, 7) == 0);
      iv_v   = ($urandom_range(0, 2) == 0);
      ireg_v = $urandom_range(0, 7);
      rr1_v  = $urandom_range(0, 7);
      rr2_v  = $urandom_range(0, 7);
      for (int i = 0; i < N; i++) begin
        if (!req_v[i] && $urandom_range(0, 1) == 1) begin
          req_v[i] = 1'b1; addr_v[i] = $urandom_range(0, 7); data_v[i] = $urandom;
        end
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
